// File: rtl/register_bank_pkg.sv
// Shared defaults and slicing helper for the multi-ported register bank.
package register_bank_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_ADDR_W   = 5;
  localparam int unsigned DEF_NUM_RD   = 4;
  localparam int unsigned DEF_NUM_WR   = 2;
  localparam int unsigned DEF_ZERO_REG = 1;
  localparam int unsigned DEF_BYPASS   = 1;

  // Low bit of port's field inside a flattened per-port bus.
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/register_bank_mp_wr_arbiter.sv
// Resolves write-port priority per address (highest index wins) and flags
// same-address collisions between enabled ports.
module wr_arbiter
  import register_bank_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_WR   = DEF_NUM_WR,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]       wr_addr,
  output logic [(2**ADDR_W)*NUM_WR-1:0]  win_sel,
  output logic                           conflict
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [NUM_WR-1:0] port_valid;

  // Writes to a hard-wired zero register never participate at all.
  always_comb begin
    port_valid = '0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      port_valid[p] = wr_en[p] &&
                      !((ZERO_REG != 0) && (wr_addr[slice_lo(p, ADDR_W) +: ADDR_W] == '0));
    end
  end

  always_comb begin
    win_sel  = '0;
    conflict = 1'b0;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (port_valid[p] && (wr_addr[slice_lo(p, ADDR_W) +: ADDR_W] == ADDR_W'(a))) begin
          if (|win_sel[a*NUM_WR +: NUM_WR]) conflict = 1'b1;
          win_sel[a*NUM_WR +: NUM_WR] = '0;
          win_sel[a*NUM_WR + p]       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/register_bank_mp.sv
// Multi-ported flop register bank with write bypass, busy scoreboard and
// write-collision detection.
module register_bank_mp
  import register_bank_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned NUM_WR   = DEF_NUM_WR,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG,
  parameter int unsigned BYPASS   = DEF_BYPASS
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [2**ADDR_W-1:0]       busy_vec,
  output logic                       wr_conflict
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]       regs   [DEPTH];
  logic [DEPTH-1:0]        busy;
  logic [DEPTH-1:0]        busy_next;
  logic [DEPTH*NUM_WR-1:0] win_sel;
  logic                    conflict;
  logic [DEPTH-1:0]        wr_hit;
  logic [DATA_W-1:0]       wr_val [DEPTH];
  logic                    rsv_valid;
  logic [ADDR_W-1:0]       ra;

  wr_arbiter #(
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_wr_arbiter (
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .win_sel  (win_sel),
    .conflict (conflict)
  );

  always_comb begin
    for (int unsigned a = 0; a < DEPTH; a++) begin
      wr_hit[a] = |win_sel[a*NUM_WR +: NUM_WR];
      wr_val[a] = '0;
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (win_sel[a*NUM_WR + p]) wr_val[a] = wr_data[slice_lo(p, DATA_W) +: DATA_W];
      end
    end
  end

  assign rsv_valid = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Reserve is applied after the write clear so the newer producer keeps the bit.
  always_comb begin
    busy_next = busy & ~wr_hit;
    if (rsv_valid) busy_next[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned a = 0; a < DEPTH; a++) regs[a] <= '0;
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        if (wr_hit[a]) regs[a] <= wr_val[a];
      end
      busy        <= busy_next;
      wr_conflict <= conflict;
    end
  end

  assign busy_vec = busy;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
      if (reset_n && !((ZERO_REG != 0) && (ra == '0))) begin
        if ((BYPASS != 0) && wr_hit[ra]) begin
          rd_data[slice_lo(i, DATA_W) +: DATA_W] = wr_val[ra];
          rd_busy[i] = 1'b0;
        end else begin
          rd_data[slice_lo(i, DATA_W) +: DATA_W] = regs[ra];
          rd_busy[i] = busy[ra];
        end
      end
    end
  end

endmodule
